// File: rtl/nios_system_pkg.sv
// rtl/nios_system_pkg.sv - shared state encoding and sysid word addresses
package nios_system_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_WT_ID = 3'd2,
    ST_RD_TS = 3'd3,
    ST_WT_TS = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/nios_system_sysid_checker.sv
// rtl/nios_system_sysid_checker.sv - reads sysid id/timestamp over Avalon-MM and checks them
// One non-overlapping read per word; each transaction bounded by TIMEOUT cycles.
module nios_system_sysid_checker
  import nios_system_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TS = 32'd1581583582,
  parameter logic [15:0] TIMEOUT     = 16'd255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_word,
  output logic [31:0] ts_word,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_tmo_cnt;
  logic        r_pass;
  logic        r_timeout_err;
  logic [31:0] r_id_word;
  logic [31:0] r_ts_word;

  logic w_in_xfer;
  logic w_tmo_hit;
  logic w_take_id;
  logic w_take_ts;
  logic w_enter_rd;
  logic w_tmo_flag;

  assign w_in_xfer  = (r_state == ST_RD_ID) || (r_state == ST_WT_ID) ||
                      (r_state == ST_RD_TS) || (r_state == ST_WT_TS);
  // The cycle in which the counter would reach TIMEOUT is the last one allowed.
  assign w_tmo_hit  = w_in_xfer && (r_tmo_cnt == (TIMEOUT - 16'd1));
  assign w_take_id  = (r_state == ST_WT_ID) && avm_readdatavalid;
  assign w_take_ts  = (r_state == ST_WT_TS) && avm_readdatavalid;
  assign w_enter_rd = ((r_state == ST_IDLE) && start) || w_take_id;
  assign w_tmo_flag = w_tmo_hit && !w_take_id && !w_take_ts;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_next = ST_RD_ID;
      ST_RD_ID: begin
        if (w_tmo_hit)             w_next = ST_FIN;
        else if (!avm_waitrequest) w_next = ST_WT_ID;
      end
      ST_WT_ID: begin
        if (avm_readdatavalid)     w_next = ST_RD_TS;
        else if (w_tmo_hit)        w_next = ST_FIN;
      end
      ST_RD_TS: begin
        if (w_tmo_hit)             w_next = ST_FIN;
        else if (!avm_waitrequest) w_next = ST_WT_TS;
      end
      ST_WT_TS: begin
        if (avm_readdatavalid || w_tmo_hit) w_next = ST_FIN;
      end
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt <= 16'd0;
    end else if (w_enter_rd) begin
      r_tmo_cnt <= 16'd0;
    end else if (w_in_xfer) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pass        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_id_word     <= 32'd0;
      r_ts_word     <= 32'd0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_pass        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_id_word     <= 32'd0;
      r_ts_word     <= 32'd0;
    end else if (w_take_id) begin
      r_id_word     <= avm_readdata;
    end else if (w_take_ts) begin
      r_ts_word     <= avm_readdata;
      // Compare against the word arriving now, not the stale register.
      r_pass        <= (r_id_word == EXPECTED_ID) && (avm_readdata == EXPECTED_TS) &&
                       !r_timeout_err;
    end else if (w_tmo_flag) begin
      r_timeout_err <= 1'b1;
      r_pass        <= 1'b0;
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_FIN);
  assign pass        = r_pass;
  assign timeout_err = r_timeout_err;
  assign id_word     = r_id_word;
  assign ts_word     = r_ts_word;
  assign avm_read    = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
  assign avm_address = (r_state == ST_RD_TS) ? ADDR_TS : ADDR_ID;

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// tb/tb_nios_system_sysid_checker.sv - scoreboard bench with a behavioural sysid slave
// Expected results come from per-word transaction lengths against TIMEOUT.
module tb_nios_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1581583582;
  localparam int          TMO    = 8;
  localparam int          NEVER  = 0;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout_err;
  logic [31:0] id_word;
  logic [31:0] ts_word;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  nios_system_sysid_checker #(
    .EXPECTED_ID(EXP_ID),
    .EXPECTED_TS(EXP_TS),
    .TIMEOUT    (16'(TMO))
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .timeout_err      (timeout_err),
    .id_word          (id_word),
    .ts_word          (ts_word),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned start_cyc;
    int unsigned lat;
    logic        pass;
    logic        terr;
    logic [31:0] id;
    logic [31:0] ts;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  // Slave behaviour per word: stall cycles, data latency after accept (0 = never), data.
  int          cfg_w[2];
  int          cfg_l[2];
  logic [31:0] cfg_d[2];
  logic        inject_rdv = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int phase_len(input int w, input int l);
    return (l == NEVER) ? 1000000 : (w + 1 + l);
  endfunction

  task automatic run_check(input int w0, input int l0, input logic [31:0] d0,
                           input int w1, input int l1, input logic [31:0] d1);
    exp_t e;
    int   p0;
    int   p1;
    cfg_w[0] = w0; cfg_l[0] = l0; cfg_d[0] = d0;
    cfg_w[1] = w1; cfg_l[1] = l1; cfg_d[1] = d1;
    p0 = phase_len(w0, l0);
    p1 = phase_len(w1, l1);
    e.start_cyc = cyc;
    if (p0 > TMO) begin
      e.lat = 1 + TMO; e.terr = 1'b1; e.id = 32'd0; e.ts = 32'd0;
    end else if (p1 > TMO) begin
      e.lat = 1 + p0 + TMO; e.terr = 1'b1; e.id = d0; e.ts = 32'd0;
    end else begin
      e.lat = 1 + p0 + p1; e.terr = 1'b0; e.id = d0; e.ts = d1;
    end
    e.pass = !e.terr && (d0 == EXP_ID) && (d1 == EXP_TS);
    sb_q.push_back(e);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) step();
    chk("drain_queue", sb_q.size(), 0);
    repeat (6) step();
  endtask

  // Slave: decides each cycle's waitrequest/readdatavalid from the master's current request.
  initial begin : slave
    int          stall_cnt;
    int          pend_cnt;
    logic [31:0] pend_data;
    stall_cnt = 0;
    pend_cnt  = 0;
    pend_data = 32'd0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'd0;
    forever begin
      step();
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = pend_data;
        end
      end
      if (inject_rdv) begin
        avm_readdatavalid = 1'b1;
        inject_rdv        = 1'b0;
      end
      if (avm_read) begin
        if (stall_cnt < cfg_w[avm_address]) begin
          avm_waitrequest = 1'b1;
        end else begin
          avm_waitrequest = 1'b0;
          pend_cnt        = cfg_l[avm_address];
          pend_data       = cfg_d[avm_address];
        end
        stall_cnt++;
      end else begin
        stall_cnt       = 0;
        avm_waitrequest = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : monitor
    exp_t e;
    logic prev_read = 1'b0;
    logic prev_wait = 1'b0;
    logic prev_addr = 1'b0;
    forever begin
      step();
      if (reset_n === 1'b1) begin
        if (done) begin
          if (sb_q.size() == 0) begin
            chk("done_without_expect", done, 0);
          end else begin
            e = sb_q.pop_front();
            chk("pass",        pass,        e.pass);
            chk("timeout_err", timeout_err, e.terr);
            chk("id_word",     id_word,     e.id);
            chk("ts_word",     ts_word,     e.ts);
            chk("latency",     cyc - e.start_cyc, e.lat);
            chk("read_at_done", avm_read,   0);
            chk("busy_at_done", busy,       1);
          end
        end else if (prev_read && prev_wait) begin
          chk("stall_read_held", avm_read,    1);
          chk("stall_addr_held", avm_address, prev_addr);
        end
      end
      prev_read = avm_read;
      prev_wait = avm_waitrequest;
      prev_addr = avm_address;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset_n = 1'b0;
    start   = 1'b0;
    cfg_w = '{0, 0}; cfg_l = '{1, 1}; cfg_d = '{EXP_ID, EXP_TS};
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_id",   id_word, 0);
    chk("rst_ts",   ts_word, 0);
    chk("rst_read", avm_read, 0);
    chk("rst_addr", avm_address, 0);
    reset_n = 1'b1;
    repeat (2) step();

    run_check(0, 1, EXP_ID, 0, 1, EXP_TS);       wait_drain();
    run_check(0, 1, 32'h0000_0001, 0, 1, EXP_TS); wait_drain();
    run_check(3, 2, EXP_ID, 3, 2, EXP_TS);       wait_drain();
    run_check(0, 1, EXP_ID, 0, NEVER, EXP_TS);   wait_drain();
    run_check(3, 4, EXP_ID, 0, 1, EXP_TS);       wait_drain();
    run_check(4, 4, EXP_ID, 0, 1, EXP_TS);       wait_drain();
    run_check(0, 1, EXP_ID, 3, 4, EXP_TS);       wait_drain();
    run_check(20, 1, EXP_ID, 0, 1, EXP_TS);      wait_drain();
    run_check(0, 1, EXP_ID, 0, 1, 32'hDEAD_BEEF); wait_drain();

    // Spurious data while idle and a second start while busy are both ignored.
    inject_rdv = 1'b1;
    repeat (2) step();
    run_check(0, 1, EXP_ID, 0, 1, EXP_TS);
    repeat (2) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_drain();
    inject_rdv = 1'b1;
    repeat (3) step();
    chk("held_pass", pass, 1);
    chk("held_terr", timeout_err, 0);
    chk("held_id",   id_word, EXP_ID);
    chk("held_ts",   ts_word, EXP_TS);
    chk("held_idle", busy, 0);

    // Reset while waiting for word 0; its late data lands after release.
    run_check(0, 4, EXP_ID, 0, 1, EXP_TS);
    step();
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_pass", pass, 0);
    chk("midrst_terr", timeout_err, 0);
    chk("midrst_id",   id_word, 0);
    chk("midrst_ts",   ts_word, 0);
    chk("midrst_read", avm_read, 0);
    chk("midrst_addr", avm_address, 0);
    sb_q.delete();
    step();
    step();
    reset_n = 1'b1;
    repeat (8) step();
    chk("postrst_idle", busy, 0);
    run_check(0, 1, EXP_ID, 0, 1, EXP_TS);       wait_drain();

    for (int i = 0; i < 30; i++) begin
      int          w0;
      int          w1;
      int          l0;
      int          l1;
      logic [31:0] d0;
      logic [31:0] d1;
      w0 = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(0, 4));
      w1 = int'($urandom_range(0, 4));
      l0 = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, 4));
      l1 = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, 4));
      d0 = ($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP_ID;
      d1 = ($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP_TS;
      run_check(w0, l0, d0, w1, l1, d1);
      wait_drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nios_system_sysid_checker.md
NIOS_SYSTEM_SYSID_CHECKER -- requirements
Module: nios_system_sysid_checker

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  EXPECTED_ID  32'd0  value required at sysid word 0.
  EXPECTED_TS  32'd1581583582  value required at sysid word 1.
  TIMEOUT  16'd255  maximum cycles allowed per read transaction, 1..65535.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clock  in  1  sole clock; all state on rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  start  in  1  single-cycle request to run one check.
  busy  out  1  check in progress.
  done  out  1  one-cycle pulse at check completion.
  pass  out  1  both words matched; valid from done, held until next accepted start.
  timeout_err  out  1  a transaction exceeded TIMEOUT; held like pass.
  id_word  out  32  captured word 0.
  ts_word  out  32  captured word 1.
  avm_address  out  1  Avalon-MM master word address.
  avm_read  out  1  Avalon-MM read request.
  avm_waitrequest  in  1  slave stall.
  avm_readdata  in  32  read data.
  avm_readdatavalid  in  1  read data qualifier.

Function
REQ-003 The FSM SHALL have states IDLE, RD_ID, WT_ID, RD_TS, WT_TS and FIN.
REQ-004 In IDLE, start=1 SHALL clear pass, timeout_err, id_word and ts_word and move to RD_ID on the next edge; start in any other state SHALL be ignored.
REQ-005 RD_ID SHALL drive avm_read=1 and avm_address=0, holding both stable while avm_waitrequest=1.
REQ-006 On avm_waitrequest=0 in RD_ID, the FSM SHALL move to WT_ID; RD_TS/WT_TS SHALL behave identically with avm_address=1.
REQ-007 avm_read SHALL be 0 in all other states, so each check issues exactly one read per word with no overlapping reads.
REQ-008 In WT_ID, avm_readdatavalid=1 SHALL capture avm_readdata into id_word and move to RD_TS; in WT_TS, it SHALL capture into ts_word and move to FIN.
REQ-009 avm_readdatavalid SHALL be ignored outside WT_ID/WT_TS, including in the acceptance cycle of RD_*.
REQ-010 A 16-bit timeout counter SHALL clear on every entry to RD_ID or RD_TS and increment each cycle spent in RD_*/WT_*.
REQ-011 When the timeout counter reaches TIMEOUT before the transaction completes, the FSM SHALL set timeout_err=1 and go to FIN with pass=0; avm_read drops in that same transition.
REQ-012 Timeout and readdatavalid in the same cycle SHALL resolve in favour of the data, so no timeout is flagged.
REQ-013 On entry to FIN, pass SHALL be set to (id_word==EXPECTED_ID && ts_word==EXPECTED_TS && !timeout_err), using the freshly captured values.
REQ-014 FIN SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 With waitrequest=0 and readdatavalid in the cycle after accept, start-to-done latency SHALL be 5 cycles: start edge, RD_ID, WT_ID, RD_TS, WT_TS, then done in FIN.

Reset
REQ-017 reset_n=0 SHALL asynchronously force IDLE, avm_read=0, avm_address=0, busy=0, done=0, pass=0, timeout_err=0, id_word=0, ts_word=0 and timeout counter=0.
REQ-018 Reset mid-check SHALL abandon the transaction with no done pulse; a readdatavalid arriving after reset release SHALL be ignored per REQ-009.

Structure
REQ-019 The state encoding and the sysid word addresses (ID=0, TS=1) SHALL reside in the shared package nios_system_pkg.
REQ-020 The design SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-021 Zero-wait slave returning 0 at address 0 and 1581583582 at address 1, pulse start -> done 5 cycles later, pass=1, timeout_err=0, id_word=0, ts_word=1581583582.
REQ-022 Slave returning 32'h0000_0001 at address 0 -> done with pass=0, timeout_err=0, id_word=1.
REQ-023 waitrequest held 3 cycles on each read with readdatavalid 2 cycles after accept -> avm_address/avm_read stable while stalled, pass=1, latency 13 cycles.
REQ-024 TIMEOUT=8 with the slave never asserting readdatavalid for word 1 -> done 8 cycles after RD_TS entry, timeout_err=1, pass=0, avm_read=0.
REQ-025 Second start while busy, plus a spurious readdatavalid in IDLE -> both ignored, one done pulse only, captured values unchanged.
REQ-026 reset_n pulsed low during WT_ID -> all outputs 0 immediately, no done; a subsequent start completes normally with pass=1.
